seq_fsm_tbl_prog: RTL and testbench

- Runtime-programmable, table-driven Moore FSM. Parametrised in state count, input width and output width.
- Next-state table and per-state output table are held in registers and written through a simple config port.
- Used wherever the design needs small control FSMs whose transition tables are decided by software or test, not fixed in RTL.
- Current state and Moore output are exported for observation.

---
 rtl/seq_fsm_tbl_prog_if.sv | 42 ++++
 rtl/seq_fsm_tbl_prog.sv | 104 ++++++++++
 tb/tb_seq_fsm_tbl_prog.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_fsm_tbl_prog_if.sv
// seq_fsm_tbl_prog_if: step, config and observation bundle
// for the table-programmable Moore FSM.
interface seq_fsm_tbl_prog_if #(
  parameter int NSTATES = 4,
  parameter int NIN     = 2,
  parameter int NOUT    = 1
);
  localparam int SW = $clog2(NSTATES);
  localparam int AW = SW + NIN;
  localparam int DW = (SW > NOUT) ? SW : NOUT;

  logic            en;
  logic [NIN-1:0]  in_;
  logic            cfg_val;
  logic            cfg_sel;
  logic [AW-1:0]   cfg_addr;
  logic [DW-1:0]   cfg_data;
  logic [SW-1:0]   state;
  logic [NOUT-1:0] out;
  logic            cfg_err;
`ifdef SEQ_FSM_TBL_PROG_TRANS_CNT_EN
  logic [15:0]     trans_count;
`endif

  modport master (
    output en, in_, cfg_val, cfg_sel,
    output cfg_addr, cfg_data,
`ifdef SEQ_FSM_TBL_PROG_TRANS_CNT_EN
    input  trans_count,
`endif
    input  state, out, cfg_err
  );

  modport slave (
    input  en, in_, cfg_val, cfg_sel,
    input  cfg_addr, cfg_data,
`ifdef SEQ_FSM_TBL_PROG_TRANS_CNT_EN
    output trans_count,
`endif
    output state, out, cfg_err
  );
endinterface

// File: rtl/seq_fsm_tbl_prog.sv
// seq_fsm_tbl_prog: runtime-programmable table-driven Moore FSM.
// Optional macro SEQ_FSM_TBL_PROG_TRANS_CNT_EN adds trans_count.
module seq_fsm_tbl_prog #(
  parameter int NSTATES = 4,
  parameter int NIN     = 2,
  parameter int NOUT    = 1
) (
  input logic               clk,
  input logic               reset,
  seq_fsm_tbl_prog_if.slave bus
);
  localparam int SW   = $clog2(NSTATES);
  localparam int AW   = SW + NIN;
  localparam int DW   = (SW > NOUT) ? SW : NOUT;
  localparam int NENT = NSTATES << NIN;
  localparam logic [SW:0] NS_L = (SW+1)'(NSTATES);

  logic [SW-1:0]   ns_tbl  [NENT];
  logic [NOUT-1:0] out_tbl [NSTATES];
  logic [SW-1:0]   state_q;
  logic [SW-1:0]   state_d;
  logic [AW-1:0]   rd_idx;
  logic            ns_ok;
  logic            out_ok;
  logic            ns_we;
  logic            out_we;
  logic            err_d;
  logic            err_q;
  logic            cfg_unused;

  // high data bits are don't-care for either table
  assign cfg_unused = ^bus.cfg_data;

  // range checks keep every stored state index below NSTATES
  always_comb begin
    ns_ok  = ({1'b0, bus.cfg_addr[AW-1:NIN]} < NS_L)
          && ({1'b0, bus.cfg_data[SW-1:0]} < NS_L);
    out_ok = ({1'b0, bus.cfg_addr[SW-1:0]} < NS_L)
          && (bus.cfg_addr[AW-1:SW] == '0);
    ns_we  = bus.cfg_val && !bus.cfg_sel && ns_ok;
    out_we = bus.cfg_val && bus.cfg_sel && out_ok;
    err_d  = bus.cfg_val
          && !(bus.cfg_sel ? out_ok : ns_ok);
  end

  // next state looks up the pre-write table entry
  always_comb begin
    rd_idx  = {state_q, bus.in_};
    state_d = state_q;
    if (bus.en) state_d = ns_tbl[rd_idx];
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= '0;
    else       state_q <= state_d;
  end

  // next-state table, reset to hold-in-place
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NENT; k++)
        ns_tbl[k] <= SW'(k >> NIN);
    end else if (ns_we) begin
      ns_tbl[bus.cfg_addr] <= bus.cfg_data[SW-1:0];
    end
  end

  // output table, reset to all zero
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NSTATES; k++)
        out_tbl[k] <= '0;
    end else if (out_we) begin
      out_tbl[bus.cfg_addr[SW-1:0]] <=
        bus.cfg_data[NOUT-1:0];
    end
  end

  // one-cycle pulse for a rejected write
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign bus.state   = state_q;
  assign bus.out     = out_tbl[state_q];
  assign bus.cfg_err = err_q;

`ifdef SEQ_FSM_TBL_PROG_TRANS_CNT_EN
  logic [15:0] cnt_q;

  // saturating count of real state changes
  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else if (state_d != state_q
             && cnt_q != 16'hFFFF)
      cnt_q <= cnt_q + 16'd1;
  end

  assign bus.trans_count = cnt_q;
`endif
endmodule

// File: tb/tb_seq_fsm_tbl_prog.sv
// tb_seq_fsm_tbl_prog: scoreboard bench for seq_fsm_tbl_prog,
// one 4-state instance and one 5-state range-check instance.
module tb_seq_fsm_tbl_prog;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_fsm_tbl_prog_if #(.NSTATES(4), .NIN(2), .NOUT(1)) a_if();
  seq_fsm_tbl_prog_if #(.NSTATES(5), .NIN(2), .NOUT(1)) b_if();

  seq_fsm_tbl_prog #(.NSTATES(4), .NIN(2), .NOUT(1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if.slave)
  );

  seq_fsm_tbl_prog #(.NSTATES(5), .NIN(2), .NOUT(1)) u_dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if.slave)
  );

  typedef struct {
    int st;
    int o;
    int err;
    int cnt;
  } exp_t;

  exp_t q[$];
  exp_t q5[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  int          m_ns [16];
  int          m_out[4];
  int          m_st;
  int          m_cnt;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_ns[k] = k >> 2;
    for (int k = 0; k < 4; k++) m_out[k] = 0;
    m_st  = 0;
    m_cnt = 0;
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      check({tag, "_empty"}, 1, 0);
      return;
    end
    e = q.pop_front();
    check({tag, "_st"}, 32'(a_if.state), e.st);
    check({tag, "_out"}, 32'(a_if.out), e.o);
    check({tag, "_err"}, 32'(a_if.cfg_err), e.err);
`ifdef SEQ_FSM_TBL_PROG_TRANS_CNT_EN
    check({tag, "_cnt"}, 32'(a_if.trans_count), e.cnt);
`endif
  endtask

  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    reset        = 1'b1;
    a_if.en       = 1'b1;
    a_if.in_      = 2'd2;
    a_if.cfg_val  = 1'b1;
    a_if.cfg_sel  = 1'b0;
    a_if.cfg_addr = 4'd1;
    a_if.cfg_data = 2'd3;
    model_reset();
    e = '{0, 0, 0, 0};
    q.push_back(e);
    @(posedge clk);
    #1;
    pop_cmp("reset");
  endtask

  task automatic cyc(input bit e_n, input int i,
                     input bit cv = 1'b0,
                     input bit sel = 1'b0,
                     input int addr = 0,
                     input int data = 0);
    exp_t e;
    int   nxt;
    bit   ok;
    @(negedge clk);
    reset        = 1'b0;
    a_if.en       = e_n;
    a_if.in_      = 2'(i);
    a_if.cfg_val  = cv;
    a_if.cfg_sel  = sel;
    a_if.cfg_addr = 4'(addr);
    a_if.cfg_data = 2'(data);
    nxt = e_n ? m_ns[m_st*4 + i] : m_st;
    if (sel) ok = (addr / 4) == 0;
    else     ok = (addr / 4) < 4 && data < 4;
    if (cv && ok) begin
      if (sel) m_out[addr % 4] = data % 2;
      else     m_ns[addr] = data;
    end
    if (nxt != m_st && m_cnt != 65535) m_cnt++;
    m_st = nxt;
    e = '{m_st, m_out[m_st], (cv && !ok) ? 1 : 0, m_cnt};
    q.push_back(e);
    @(posedge clk);
    #1;
    pop_cmp("cyc");
  endtask

  task automatic prog();
    int rows[16];
    rows = '{0, 1, 0, 3, 2, 1, 0, 3,
             0, 3, 0, 3, 2, 1, 0, 3};
    for (int k = 0; k < 16; k++)
      cyc(1'b0, 0, 1'b1, 1'b0, k, rows[k]);
    cyc(1'b0, 0, 1'b1, 1'b1, 3, 1);
  endtask

  task automatic cyc5(input bit e_n, input int i,
                      input bit cv, input bit sel,
                      input int addr, input int data,
                      input int xs, input int xo,
                      input int xe);
    exp_t e;
    @(negedge clk);
    b_if.en       = e_n;
    b_if.in_      = 2'(i);
    b_if.cfg_val  = cv;
    b_if.cfg_sel  = sel;
    b_if.cfg_addr = 5'(addr);
    b_if.cfg_data = 3'(data);
    e = '{xs, xo, xe, 0};
    q5.push_back(e);
    @(posedge clk);
    #1;
    if (q5.size() == 0) begin
      check("n5_empty", 1, 0);
    end else begin
      e = q5.pop_front();
      check("n5_st", 32'(b_if.state), e.st);
      check("n5_out", 32'(b_if.out), e.o);
      check("n5_err", 32'(b_if.cfg_err), e.err);
    end
  endtask

  initial begin
    reset         = 1'b1;
    a_if.en       = 1'b0;
    a_if.in_      = '0;
    a_if.cfg_val  = 1'b0;
    a_if.cfg_sel  = 1'b0;
    a_if.cfg_addr = '0;
    a_if.cfg_data = '0;
    b_if.en       = 1'b0;
    b_if.in_      = '0;
    b_if.cfg_val  = 1'b0;
    b_if.cfg_sel  = 1'b0;
    b_if.cfg_addr = '0;
    b_if.cfg_data = '0;

    do_reset();
    for (int k = 0; k < 8; k++) cyc(1'b1, k % 4);

    prog();
    cyc(1'b1, 1);
    check("seq_b", 32'(a_if.state), 1);
    cyc(1'b1, 0);
    cyc(1'b1, 1);
    check("seq_d_out", 32'(a_if.out), 1);
    cyc(1'b1, 0);
    check("seq_c", 32'(a_if.state), 2);

    cyc(1'b1, 1);
    cyc(1'b1, 1);
    for (int k = 0; k < 5; k++) cyc(1'b0, 0);
    check("en_hold", 32'(a_if.state), 1);
    cyc(1'b1, 0);
    check("en_step", 32'(a_if.state), 2);

    cyc(1'b0, 0, 1'b1, 1'b1, 4, 1);
    cyc(1'b0, 0);

    do_reset();
    cyc(1'b0, 0, 1'b1, 1'b0, 1, 1);
    cyc(1'b1, 1, 1'b1, 1'b0, 1, 3);
    check("coll_old", 32'(a_if.state), 1);
    do_reset();
    cyc(1'b0, 0, 1'b1, 1'b0, 1, 3);
    cyc(1'b1, 1);
    check("coll_new", 32'(a_if.state), 3);

    do_reset();
    prog();
    cyc(1'b1, 1);
    cyc(1'b1, 0);
    cyc(1'b1, 1);
`ifdef SEQ_FSM_TBL_PROG_TRANS_CNT_EN
    check("cnt3", 32'(a_if.trans_count), 3);
`endif
    do_reset();
    cyc(1'b1, 1);
    check("rst_hold", 32'(a_if.state), 0);

    cyc5(1'b0, 0, 1'b1, 1'b0, 0, 6, 0, 0, 1);
    cyc5(1'b1, 0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    cyc5(1'b0, 0, 1'b1, 1'b1, 5, 1, 0, 0, 1);
    cyc5(1'b0, 0, 1'b1, 1'b0, 0, 4, 0, 0, 0);
    cyc5(1'b0, 0, 1'b1, 1'b1, 4, 1, 0, 0, 0);
    cyc5(1'b1, 0, 1'b0, 1'b0, 0, 0, 4, 1, 0);
    cyc5(1'b0, 0, 1'b1, 1'b0, 20, 0, 4, 1, 1);
    cyc5(1'b1, 1, 1'b0, 1'b0, 0, 0, 4, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
